demux3_buffered: RTL and testbench
==================================

Name: demux3_buffered

Overview:
- 32-bit one-to-three router: the inverse of the CPU's 3-input datapath select muxes.
- Accepts one word plus a 2-bit destination select over a valid/ready handshake.
- Places the word in a one-entry holding register for the chosen output channel.
- Feeds three independent consumers (e.g. writeback, HI/LO unit, store path), each with its own valid/ready handshake.

Parameters:
- WIDTH, 32, data word width in bits.
- CNT_W, 8, width of the saturating dropped-word counter.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  router can accept the presented word this cycle.
- in_data  input  WIDTH  word to route.
- in_sel  input  2  destination: 0, 1 or 2; 3 is illegal.
- out0_valid / out1_valid / out2_valid  output  1 each  channel k holds a word.
- out0_ready / out1_ready / out2_ready  input  1 each  consumer k takes the word this cycle.
- out0_data / out1_data / out2_data  output  WIDTH each  held word of channel k.
- sel_err  output  1  one-cycle pulse: a word with in_sel==3 was accepted and dropped.
- drop_count  output  CNT_W  number of illegal-select words dropped, saturating.

Behaviour:
- State:
  - per channel k: full_k flag and buf_k register.
  - sel_err register.
  - drop_count register.
- Reset (reset==0 at clk edge) forces:
  - all full_k=0, all buf_k=0, so every outk_valid=0 and outk_data=0.
  - sel_err=0, drop_count=0.
  - Takes priority over any concurrent transfer.
  - Mid-operation reset discards all buffered words with no output handshake.
- Outputs:
  - outk_valid = full_k.
  - outk_data = buf_k.
  - Both are registered only; no combinational path from in_* to out*.
- in_ready, combinational:
  - in_sel==3: 1.
  - otherwise: !full[in_sel] | outN_ready[in_sel].
  - Depends on in_sel and out ready; never depends on in_valid.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - drain_k = full_k & outk_ready.
- Per-channel next state, channel k:
  - accept to k and drain_k in the same cycle: buf_k <= in_data, full_k stays 1. Back-to-back throughput is 1 word/cycle per channel.
  - accept to k without drain_k: buf_k <= in_data, full_k <= 1.
  - drain_k without accept to k: full_k <= 0; buf_k retains its value.
  - otherwise: hold.
- Latency: a word accepted at edge N appears on outk_valid/outk_data after edge N, i.e. 1 cycle.
- Stability: while outk_valid=1 and outk_ready=0, outk_data must not change.
- in_data and in_sel are ignored when in_valid=0.
- Illegal select:
  - accept with in_sel==3: no channel changes, sel_err <= 1 for exactly one cycle, drop_count <= drop_count+1.
  - drop_count holds at 2^CNT_W-1 once reached; it never wraps.
- Otherwise sel_err <= 0 every cycle.
- Ordering: words to the same channel leave in acceptance order. No ordering is guaranteed across channels.
- outk_ready asserted while full_k=0 has no effect.
- Channels are independent: a stalled channel blocks only inputs selecting that channel.

Test Plan:
- Reset, then in_sel=0, in_data=32'hFF44FF44, in_valid=1 for one cycle with all out ready=0 -> next cycle out0_valid=1, out0_data=32'hFF44FF44; out1_valid=out2_valid=0; in_ready=0 for in_sel=0, 1 for in_sel=1.
- Route 32'h00000001 to channel 1 and 32'hFFFFFFFF to channel 2, with out1_ready=out2_ready=0 -> both held stable for 5 cycles; set out2_ready=1 for one cycle -> out2_valid drops, out1 is unchanged.
- Channel 0 full, out0_ready=1, in_valid=1, in_sel=0, in_data=32'h33AA44FF in the same cycle -> in_ready=1, out0_valid stays 1, out0_data becomes 32'h33AA44FF. Stream 4 words back-to-back to channel 0 -> 4 words in order, 1/cycle.
- in_sel=3, in_data=32'h12345678, in_valid=1 for 3 cycles -> in_ready=1 each cycle, sel_err high for 3 cycles, drop_count=3, no outk_valid. With CNT_W=2, 5 drops -> drop_count=3.
- Load all three channels, then reset=0 for one cycle while in_valid=1 -> after the edge all outk_valid=0, outk_data=0, drop_count=0, and the input word is not captured.

Source files
------------

// File: rtl/demux3_buffered.sv
// rtl/demux3_buffered.sv - one-to-three word router with a one-entry holding register per channel
//
// demux3_buffered_chan : one output channel, a single-entry register with a valid flag
//    clk, reset        : system clock, synchronous active-low reset
//    load, load_data   : capture a new word this cycle (wins over a drain)
//    out_valid/ready   : consumer handshake
//    out_data          : held word, stable while out_valid & !out_ready
//
// demux3_buffered : routes one WIDTH-bit word per cycle to channel in_sel (0..2)
//    clk, reset                : system clock, synchronous active-low reset
//    in_valid/in_ready         : producer handshake; in_ready depends only on in_sel and channel state
//    in_data, in_sel           : word and destination; in_sel==3 accepts and drops the word
//    outK_valid/ready/data     : three independent consumer handshakes, registered outputs
//    sel_err                   : one-cycle pulse for each dropped illegal-select word
//    drop_count                : saturating count of dropped words

module demux3_buffered_chan #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   logic             full_q;
   logic [WIDTH-1:0] buf_q;

   // A load in the same cycle as a drain replaces the word and keeps the
   // flag set, which gives one word per cycle through each channel.
   always_ff @(posedge clk) begin
      if (!reset) begin
         full_q <= 1'b0;
         buf_q  <= '0;
      end else if (load) begin
         full_q <= 1'b1;
         buf_q  <= load_data;
      end else if (full_q && out_ready) begin
         full_q <= 1'b0;
      end
   end

   assign out_valid = full_q;
   assign out_data  = buf_q;

endmodule

module demux3_buffered #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   output logic             out0_valid,
   input  logic             out0_ready,
   output logic [WIDTH-1:0] out0_data,
   output logic             out1_valid,
   input  logic             out1_ready,
   output logic [WIDTH-1:0] out1_data,
   output logic             out2_valid,
   input  logic             out2_ready,
   output logic [WIDTH-1:0] out2_data,
   output logic             sel_err,
   output logic [CNT_W-1:0] drop_count
);

   localparam logic [1:0] SEL_BAD = 2'd3;

   logic [CNT_W-1:0] drop_count_q;
   logic             sel_err_q;
   logic             accept;
   logic             accept_bad;
   logic [2:0]       load;

   // Readiness of the selected channel only; an illegal select is always
   // taken so a bad producer can never wedge the router.
   always_comb begin
      in_ready = 1'b1;
      case (in_sel)
         2'd0:    in_ready = !out0_valid || out0_ready;
         2'd1:    in_ready = !out1_valid || out1_ready;
         2'd2:    in_ready = !out2_valid || out2_ready;
         default: in_ready = 1'b1;
      endcase
   end

   assign accept     = in_valid && in_ready;
   assign accept_bad = accept && (in_sel == SEL_BAD);

   always_comb begin
      load = 3'b000;
      if (accept) begin
         case (in_sel)
            2'd0:    load = 3'b001;
            2'd1:    load = 3'b010;
            2'd2:    load = 3'b100;
            default: load = 3'b000;
         endcase
      end
   end

   demux3_buffered_chan #(.WIDTH(WIDTH)) u_chan0 (
      .clk       (clk),
      .reset     (reset),
      .load      (load[0]),
      .load_data (in_data),
      .out_ready (out0_ready),
      .out_valid (out0_valid),
      .out_data  (out0_data)
   );

   demux3_buffered_chan #(.WIDTH(WIDTH)) u_chan1 (
      .clk       (clk),
      .reset     (reset),
      .load      (load[1]),
      .load_data (in_data),
      .out_ready (out1_ready),
      .out_valid (out1_valid),
      .out_data  (out1_data)
   );

   demux3_buffered_chan #(.WIDTH(WIDTH)) u_chan2 (
      .clk       (clk),
      .reset     (reset),
      .load      (load[2]),
      .load_data (in_data),
      .out_ready (out2_ready),
      .out_valid (out2_valid),
      .out_data  (out2_data)
   );

   // Dropped-word bookkeeping; the counter parks at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         sel_err_q    <= 1'b0;
         drop_count_q <= '0;
      end else begin
         sel_err_q <= accept_bad;
         if (accept_bad && (drop_count_q != {CNT_W{1'b1}})) begin
            drop_count_q <= drop_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign sel_err    = sel_err_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_demux3_buffered.sv
// tb/tb_demux3_buffered.sv - scoreboard bench for demux3_buffered
module tb_demux3_buffered;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [1:0]  in_sel;
   logic        out0_valid, out1_valid, out2_valid;
   logic        out0_ready, out1_ready, out2_ready;
   logic [31:0] out0_data, out1_data, out2_data;
   logic        sel_err;
   logic [7:0]  drop_count;

   logic        s_in_ready;
   logic        s_out0_valid, s_out1_valid, s_out2_valid;
   logic [31:0] s_out0_data, s_out1_data, s_out2_data;
   logic        s_sel_err;
   logic [1:0]  s_drop_count;

   int total = 0;
   int bad   = 0;
   bit mon_en = 1'b0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];
   logic [31:0] q2[$];
   logic [31:0] words[4] = '{32'h11111111, 32'h22222222, 32'h44444444, 32'h88888888};

   always #5 clk = ~clk;

   demux3_buffered dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
      .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
      .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
      .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data),
      .sel_err(sel_err), .drop_count(drop_count)
   );

   demux3_buffered #(.CNT_W(2)) u_small (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_sel(in_sel),
      .out0_valid(s_out0_valid), .out0_ready(out0_ready), .out0_data(s_out0_data),
      .out1_valid(s_out1_valid), .out1_ready(out1_ready), .out1_data(s_out1_data),
      .out2_valid(s_out2_valid), .out2_ready(out2_ready), .out2_data(s_out2_data),
      .sel_err(s_sel_err), .drop_count(s_drop_count)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic mon_ch(input int k, input logic v, input logic [31:0] d, input logic r);
      int n;
      logic [31:0] f;
      n = 0;
      f = '0;
      case (k)
         0: n = q0.size();
         1: n = q1.size();
         default: n = q2.size();
      endcase
      chk($sformatf("out%0d_valid", k), {31'b0, v}, (n != 0) ? 32'd1 : 32'd0);
      if (v && n != 0) begin
         case (k)
            0: f = q0[0];
            1: f = q1[0];
            default: f = q2[0];
         endcase
         chk($sformatf("out%0d_data", k), d, f);
         if (r) begin
            case (k)
               0: void'(q0.pop_front());
               1: void'(q1.pop_front());
               default: void'(q2.pop_front());
            endcase
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon_ch(0, out0_valid, out0_data, out0_ready);
         mon_ch(1, out1_valid, out1_data, out1_ready);
         mon_ch(2, out2_valid, out2_data, out2_ready);
      end
   end

   task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   task automatic xfer(input logic [1:0] s, input logic [31:0] d, input logic exp_rdy);
      drive(1'b1, s, d);
      @(negedge clk);
      chk($sformatf("in_ready sel%0d", s), {31'b0, in_ready}, {31'b0, exp_rdy});
      @(posedge clk);
      if (exp_rdy) begin
         case (s)
            2'd0: q0.push_back(d);
            2'd1: q1.push_back(d);
            2'd2: q2.push_back(d);
            default: ;
         endcase
      end
      #1;
      drive(1'b0, 2'd0, 32'h0);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk_cleared();
      chk("rst out0_valid", {31'b0, out0_valid}, 32'd0);
      chk("rst out1_valid", {31'b0, out1_valid}, 32'd0);
      chk("rst out2_valid", {31'b0, out2_valid}, 32'd0);
      chk("rst out0_data", out0_data, 32'd0);
      chk("rst out1_data", out1_data, 32'd0);
      chk("rst out2_data", out2_data, 32'd0);
      chk("rst sel_err", {31'b0, sel_err}, 32'd0);
      chk("rst drop_count", {24'b0, drop_count}, 32'd0);
      chk("rst small valid", {29'b0, s_out0_valid, s_out1_valid, s_out2_valid}, 32'd0);
      chk("rst small data", s_out0_data | s_out1_data | s_out2_data, 32'd0);
      chk("rst small err/cnt", {29'b0, s_sel_err, s_drop_count}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      drive(1'b0, 2'd0, 32'h0);
      out0_ready = 1'b0;
      out1_ready = 1'b0;
      out2_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk_cleared();
      chk("rst small in_ready", {31'b0, s_in_ready}, 32'd1);
      mon_en = 1'b1;
      idle(1);

      // single word into channel 0, consumer stalled
      xfer(2'd0, 32'hFF44FF44, 1'b1);
      @(negedge clk);
      chk("full ch0 in_ready sel0", {31'b0, in_ready}, 32'd0);
      drive(1'b0, 2'd1, 32'h0);
      #1;
      chk("full ch0 in_ready sel1", {31'b0, in_ready}, 32'd1);
      chk("ch0 held data", out0_data, 32'hFF44FF44);
      idle(1);

      // channels 1 and 2 held, then drain only channel 2
      xfer(2'd1, 32'h00000001, 1'b1);
      xfer(2'd2, 32'hFFFFFFFF, 1'b1);
      idle(5);
      out2_ready = 1'b1;
      idle(1);
      out2_ready = 1'b0;
      @(negedge clk);
      chk("ch2 drained", {31'b0, out2_valid}, 32'd0);
      chk("ch1 untouched", out1_data, 32'h00000001);
      idle(1);
      out1_ready = 1'b1;
      idle(1);
      out1_ready = 1'b0;

      // replace-on-drain, then back-to-back stream into channel 0
      out0_ready = 1'b1;
      xfer(2'd0, 32'h33AA44FF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         xfer(2'd0, words[i], 1'b1);
      end
      idle(1);
      out0_ready = 1'b0;
      @(negedge clk);
      chk("ch0 empty after stream", {31'b0, out0_valid}, 32'd0);
      idle(1);

      // illegal selects
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 2'd3, 32'h12345678);
         @(negedge clk);
         chk("in_ready sel3", {31'b0, in_ready}, 32'd1);
         if (i > 0) chk("sel_err streak", {31'b0, sel_err}, 32'd1);
         @(posedge clk);
         #1;
      end
      drive(1'b0, 2'd0, 32'h0);
      @(negedge clk);
      chk("sel_err third", {31'b0, sel_err}, 32'd1);
      chk("drop_count 3", {24'b0, drop_count}, 32'd3);
      chk("small drop_count 3", {30'b0, s_drop_count}, 32'd3);
      idle(1);
      @(negedge clk);
      chk("sel_err clears", {31'b0, sel_err}, 32'd0);
      idle(1);
      xfer(2'd3, 32'h12345678, 1'b1);
      xfer(2'd3, 32'h12345678, 1'b1);
      @(negedge clk);
      chk("drop_count 5", {24'b0, drop_count}, 32'd5);
      chk("small drop_count saturates", {30'b0, s_drop_count}, 32'd3);
      idle(1);

      // load every channel, then reset with a word on offer
      xfer(2'd0, 32'hA0A0A0A0, 1'b1);
      xfer(2'd1, 32'hB1B1B1B1, 1'b1);
      xfer(2'd2, 32'hC2C2C2C2, 1'b1);
      out0_ready = 1'b1;
      drive(1'b1, 2'd0, 32'hDEADBEEF);
      reset = 1'b0;
      @(posedge clk);
      q0.delete();
      q1.delete();
      q2.delete();
      #1;
      reset = 1'b1;
      out0_ready = 1'b0;
      drive(1'b0, 2'd0, 32'h0);
      @(negedge clk);
      chk_cleared();
      idle(3);

      chk("scoreboard drained", q0.size() + q1.size() + q2.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
